// File: rtl/sipo_frame_ctrl_if.sv
// Bundle of the serial capture path signals: frame/serial inputs, consumer handshake and
// status outputs. The master side drives the serial pin and consumer controls; the slave
// side is the capture sequencer.
interface sipo_frame_ctrl_if #(
  parameter int unsigned DATA_W = 8
);
  logic              en;
  logic              fs;
  logic              sdi;
  logic              ready;
  logic              clr;
  logic              sft;
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              busy;
  logic              ovr;
  logic              perr;

  modport master (
    output en, fs, sdi, ready, clr,
    input  sft, data, valid, busy, ovr, perr
  );

  modport slave (
    input  en, fs, sdi, ready, clr,
    output sft, data, valid, busy, ovr, perr
  );
endinterface

// File: rtl/sipo_frame_ctrl.sv
// Serial-in/parallel-out frame sequencer. A frame-sync pulse starts a frame of DATA_W bits,
// each BIT_DIV clocks long; the last clock of each bit period carries a one-cycle shift
// strobe and the serial input is shifted MSB-first on the following edge. Completed words
// move into a holding register under a valid/ready handshake; a word arriving while the
// previous one is still unconsumed is dropped and flags a sticky overrun.
// Optional feature macro: SIPO_PARITY_EN adds a trailing even-parity bit per frame and
// reports a parity mismatch alongside the held word.
module sipo_frame_ctrl #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned BIT_DIV = 4
) (
  input logic              clk,
  input logic              rst_n,
  sipo_frame_ctrl_if.slave bus
);

  localparam int unsigned DivW = $clog2(BIT_DIV);
  localparam int unsigned CntW = $clog2(DATA_W);
  localparam logic [DivW-1:0] DivLast = DivW'(BIT_DIV - 1);
  localparam logic [DivW-1:0] DivOne  = DivW'(1);
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_W - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

`ifdef SIPO_PARITY_EN
  typedef enum logic [1:0] {StIdle, StShift, StPar, StDone} state_e;
`else
  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;
`endif

  state_e            state_q;
  logic [DivW-1:0]   div_q;
  logic [CntW-1:0]   cnt_q;
  logic [DATA_W-1:0] sr_q;
  logic              sft_q;
  logic              busy_q;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              ovr_q;
  logic              load;
  logic              accept;

`ifdef SIPO_PARITY_EN
  logic              par_q;
  logic              perr_q;
`endif

  // Sequencer: strobe and busy are registered by looking one cycle ahead at the divider.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      div_q   <= '0;
      cnt_q   <= '0;
      sr_q    <= '0;
      sft_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef SIPO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else if (!bus.en) begin
      // Disable aborts the frame; a partial word never reaches the holding register.
      state_q <= StIdle;
      div_q   <= '0;
      cnt_q   <= '0;
      sr_q    <= '0;
      sft_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.fs) begin
            state_q <= StShift;
            div_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            sft_q   <= 1'b0;
          end
        end
        StShift: begin
          if (div_q == DivLast) begin
            sr_q  <= {sr_q[DATA_W-2:0], bus.sdi};
            div_q <= '0;
            sft_q <= 1'b0;
            if (cnt_q == CntLast) begin
              cnt_q   <= '0;
`ifdef SIPO_PARITY_EN
              state_q <= StPar;
`else
              state_q <= StDone;
`endif
            end else begin
              cnt_q <= cnt_q + CntOne;
            end
          end else begin
            div_q <= div_q + DivOne;
            sft_q <= ((div_q + DivOne) == DivLast);
          end
        end
`ifdef SIPO_PARITY_EN
        StPar: begin
          if (div_q == DivLast) begin
            par_q   <= bus.sdi;
            div_q   <= '0;
            sft_q   <= 1'b0;
            state_q <= StDone;
          end else begin
            div_q <= div_q + DivOne;
            sft_q <= ((div_q + DivOne) == DivLast);
          end
        end
`endif
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          sft_q   <= 1'b0;
        end
      endcase
    end
  end

  // The DONE exit edge offers the word; it is taken only if the holding slot is free
  // or being emptied on the same edge.
  assign load   = (state_q == StDone) && bus.en;
  assign accept = !valid_q || bus.ready;

  // Holding register and handshake; a coinciding load keeps valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
`ifdef SIPO_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else if (load && accept) begin
      data_q  <= sr_q;
      valid_q <= 1'b1;
`ifdef SIPO_PARITY_EN
      perr_q  <= ^{sr_q, par_q};
`endif
    end else if (valid_q && bus.ready) begin
      valid_q <= 1'b0;
    end
  end

  // Sticky overrun; a new overrun beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_q <= 1'b0;
    end else if (load && !accept) begin
      ovr_q <= 1'b1;
    end else if (bus.clr) begin
      ovr_q <= 1'b0;
    end
  end

  assign bus.sft   = sft_q;
  assign bus.busy  = busy_q;
  assign bus.data  = data_q;
  assign bus.valid = valid_q;
  assign bus.ovr   = ovr_q;
`ifdef SIPO_PARITY_EN
  assign bus.perr  = perr_q;
`else
  assign bus.perr  = 1'b0;
`endif

endmodule
